count_sched: RTL and testbench
==============================

# count_sched

Round-robin scheduler that shares one 3-bit counting resource among several requesters. A granted requester receives one counting run from 0 up to its own terminal value, then a one-cycle done pulse, and ownership passes to the next requester in rotation. It sits between client blocks and the counter datapath, and both sequences and arbitrates the counter.

## Interface
- NREQ, 4, number of requesters (2..8)
- CW, 3, counter width; count range 0..2^CW-1

- cl  in  1  clock, rising-edge
- r  in  1  reset, asynchronous, active-high
- req  in  NREQ  request per requester, level; held high until done or abandoned
- term  in  NREQ*CW  per-requester terminal count; slice i = term[i*CW +: CW]; sampled at grant
- gnt  out  NREQ  one-hot grant, registered; all zero when no owner
- cnt  out  CW  current count of the active run
- cnt_vld  out  1  cnt is a valid count for the granted owner
- done  out  NREQ  one-hot, one-cycle pulse, run complete for that requester
- busy  out  1  high in RUN and DONE states

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, gnt=0, cnt=0, cnt_vld=0, done=0, busy=0, rotation pointer=0, latched term=0.
- IDLE: if any req bit is high, pick the first set bit at or after the pointer, wrapping modulo NREQ. Set gnt to that bit, cnt=0, latch term slice, go to RUN. If no req is set, stay in IDLE with outputs at their reset values.
- RUN: cnt_vld=1. Each cycle, if cnt==latched term, go to DONE; otherwise cnt=cnt+1.
- Counter arithmetic is modulo 2^CW. term=2^CW-1 yields a full run 0..7 and no wrap occurs inside a run. term=0 yields a single count.
- Abort: if req[owner] drops during RUN, go to IDLE at the next edge. gnt clears, cnt_vld clears, cnt=0, no done pulse, and the pointer advances to owner+1.
- DONE: done[owner]=1, gnt=0, cnt_vld=0, and the pointer is set to owner+1 mod NREQ. Always go to IDLE next.
- Changes to term after grant have no effect on the current run.
- req bits of non-owners are ignored outside IDLE.
- If the owner keeps req high after done, it is re-eligible but yields to any other pending requester.

## Timing
- req high before edge e while in IDLE: at e, gnt and cnt_vld are high with cnt=0. The grant latency is 1 cycle.
- RUN lasts term+1 cycles (cnt 0..term).
- done is high for exactly the 1 cycle following the last count. gnt is low in that same cycle.
- Back-to-back grants are spaced term+3 cycles: RUN (term+1) + DONE (1) + IDLE (1).
- All outputs are registered; there is no combinational path from req to gnt.
- Reset asserted mid-run forces the reset values immediately (async). The first grant after reset release occurs no earlier than the second rising edge after release.

## Structure
- Package count_sched_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - default NREQ and CW constants
  - a function extracting a term slice
- Sub-module rr_pick, purely combinational:
  - inputs: req vector, pointer
  - outputs: one-hot pick and its index
  - rotate, priority-encode, rotate back
- Counter, latched term, pointer and FSM live in count_sched.

## Test plan
- Reset, then req=4'b0001 with term0=3 → gnt=0001 one edge later; cnt 0,1,2,3 with cnt_vld=1; done=0001 for 1 cycle; gnt=0.
- req=4'b1111 held, all terms=1 → grant order 0,1,2,3,0; each grant is 4 cycles apart.
- term0=7 → cnt 0..7 with no early exit; done after 8 counts. term1=0 → single cnt=0, done next cycle.
- req2 drops at cnt=2 of term2=5 → IDLE next edge, no done, next grant goes to requester 3.
- r pulsed mid-run at cnt=4 → all outputs zero immediately. After release, req=4'b0110 → grant goes to requester 1 (pointer back at 0).
- term0 changed 5→1 during requester 0's run → run still ends at cnt=5.

Source files
------------

// File: rtl/count_sched_pkg.sv
// count_sched_pkg: shared state type, default sizes and term slice helper
package count_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NREQ_D = 4;
  localparam int CW_D = 3;
  function automatic logic [7:0] term_slice(input logic [63:0] t, input int i, input int w);
    return 8'((t >> (i * w)) & ((64'd1 << w) - 64'd1));
  endfunction
endpackage

// File: rtl/count_sched_rr_pick.sv
// rr_pick: round-robin pick of the first set req bit at or after ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx
);
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;
  logic [IW:0] k, sum;
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    k = '0;
    for (int i = NREQ - 1; i >= 0; i--) k = rot[i] ? (IW+1)'(i) : k;
    sum = k + {1'b0, ptr};
    idx = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
    pick = (|req) ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/count_sched.sv
// count_sched: round-robin owner of a shared counter, one run to term per grant
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int CW = CW_D
) (
  input  logic              cl,
  input  logic              r,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] term,
  output logic [NREQ-1:0]   gnt,
  output logic [CW-1:0]     cnt,
  output logic              cnt_vld,
  output logic [NREQ-1:0]   done,
  output logic              busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t st;
  logic [IW-1:0] ptr, own, pidx, nxt;
  logic [NREQ-1:0] pick;
  logic [CW-1:0] tl, tsel;
  logic armed;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (.req(req), .ptr(ptr), .pick(pick), .idx(pidx));
  assign tsel = CW'(term_slice(64'(term), int'(pidx), CW));
  assign nxt = (own == IW'(NREQ - 1)) ? '0 : own + 1'b1;
  // armed holds off grants until the second edge after reset release
  always_ff @(posedge cl or posedge r) begin
    if (r) begin
      st <= IDLE;
      gnt <= '0;
      cnt <= '0;
      cnt_vld <= 1'b0;
      done <= '0;
      busy <= 1'b0;
      ptr <= '0;
      own <= '0;
      tl <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      done <= '0;
      case (st)
        IDLE: if (armed && |req) begin
          st <= RUN;
          gnt <= pick;
          own <= pidx;
          tl <= tsel;
          cnt <= '0;
          cnt_vld <= 1'b1;
          busy <= 1'b1;
        end
        RUN: if (!req[own]) begin
          st <= IDLE;
          gnt <= '0;
          cnt <= '0;
          cnt_vld <= 1'b0;
          busy <= 1'b0;
          ptr <= nxt;
        end else if (cnt == tl) begin
          st <= DONE;
          done <= gnt;
          gnt <= '0;
          cnt <= '0;
          cnt_vld <= 1'b0;
          ptr <= nxt;
        end else cnt <= cnt + 1'b1;
        default: begin
          st <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: directed checks of grant order, run length, abort and reset
module tb_count_sched;
  logic cl = 1'b0, r = 1'b1;
  logic [3:0] req = '0;
  logic [11:0] term = '0;
  logic [3:0] gnt, done;
  logic [2:0] cnt;
  logic cnt_vld, busy;
  int checks = 0, failures = 0;
  count_sched dut (.cl(cl), .r(r), .req(req), .term(term), .gnt(gnt), .cnt(cnt),
                   .cnt_vld(cnt_vld), .done(done), .busy(busy));
  always #5 cl = ~cl;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge cl);
  endtask
  task automatic do_reset();
    r = 1'b1;
    req = '0;
    cyc();
    chk("rst_gnt", gnt, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_vld", cnt_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    r = 1'b0;
    cyc();
  endtask
  task automatic set_term(input int i, input logic [2:0] v);
    term[i*3 +: 3] = v;
  endtask
  initial begin
    do_reset();
    // single run, term 3
    set_term(0, 3);
    req = 4'b0001;
    for (int v = 0; v < 4; v++) begin
      cyc();
      chk($sformatf("t1_gnt%0d", v), gnt, 4'b0001);
      chk($sformatf("t1_cnt%0d", v), cnt, v);
      chk($sformatf("t1_vld%0d", v), cnt_vld, 1);
      chk($sformatf("t1_busy%0d", v), busy, 1);
    end
    cyc();
    chk("t1_done", done, 4'b0001);
    chk("t1_gnt_off", gnt, 0);
    chk("t1_busy_done", busy, 1);
    chk("t1_vld_off", cnt_vld, 0);
    req = '0;
    cyc();
    chk("t1_done_clr", done, 0);
    chk("t1_busy_clr", busy, 0);
    // rotation with everyone requesting, term 1
    do_reset();
    for (int i = 0; i < 4; i++) set_term(i, 1);
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      logic [3:0] oh;
      oh = 4'b0001 << ((c / 4) % 4);
      cyc();
      chk($sformatf("t2_gnt_c%0d", c), gnt, (c % 4 < 2) ? oh : 4'b0);
      chk($sformatf("t2_done_c%0d", c), done, (c % 4 == 2) ? oh : 4'b0);
      if (c % 4 < 2) chk($sformatf("t2_cnt_c%0d", c), cnt, c % 4);
    end
    req = '0;
    cyc();
    chk("t2_abort_gnt", gnt, 0);
    // full-range run then zero-length run
    do_reset();
    set_term(0, 7);
    set_term(1, 0);
    req = 4'b0001;
    for (int v = 0; v < 8; v++) begin
      cyc();
      chk($sformatf("t3_cnt%0d", v), cnt, v);
      chk($sformatf("t3_vld%0d", v), cnt_vld, 1);
      chk($sformatf("t3_nodone%0d", v), done, 0);
    end
    cyc();
    chk("t3_done0", done, 4'b0001);
    req = '0;
    cyc();
    req = 4'b0010;
    cyc();
    chk("t3_gnt1", gnt, 4'b0010);
    chk("t3_cnt1", cnt, 0);
    chk("t3_vld1", cnt_vld, 1);
    cyc();
    chk("t3_done1", done, 4'b0010);
    chk("t3_gnt1_off", gnt, 0);
    req = '0;
    cyc();
    // abort of requester 2, then requester 3 wins
    set_term(2, 5);
    set_term(3, 2);
    req = 4'b1100;
    for (int v = 0; v < 3; v++) begin
      cyc();
      chk($sformatf("t4_gnt%0d", v), gnt, 4'b0100);
      chk($sformatf("t4_cnt%0d", v), cnt, v);
    end
    req = 4'b1000;
    cyc();
    chk("t4_ab_gnt", gnt, 0);
    chk("t4_ab_done", done, 0);
    chk("t4_ab_vld", cnt_vld, 0);
    chk("t4_ab_busy", busy, 0);
    chk("t4_ab_cnt", cnt, 0);
    cyc();
    chk("t4_gnt3", gnt, 4'b1000);
    chk("t4_cnt3", cnt, 0);
    req = '0;
    cyc();
    // async reset in the middle of a run
    do_reset();
    set_term(0, 7);
    req = 4'b0001;
    for (int v = 0; v < 5; v++) cyc();
    chk("t5_pre_cnt", cnt, 4);
    chk("t5_pre_gnt", gnt, 4'b0001);
    #2 r = 1'b1;
    #1;
    chk("t5_async_gnt", gnt, 0);
    chk("t5_async_cnt", cnt, 0);
    chk("t5_async_vld", cnt_vld, 0);
    chk("t5_async_busy", busy, 0);
    req = 4'b0110;
    cyc();
    r = 1'b0;
    cyc();
    chk("t5_no_early_gnt", gnt, 0);
    cyc();
    chk("t5_gnt1", gnt, 4'b0010);
    chk("t5_cnt1", cnt, 0);
    req = '0;
    cyc();
    // term change after grant is ignored
    do_reset();
    set_term(0, 5);
    req = 4'b0001;
    cyc();
    chk("t6_cnt0", cnt, 0);
    set_term(0, 1);
    for (int v = 1; v < 6; v++) begin
      cyc();
      chk($sformatf("t6_cnt%0d", v), cnt, v);
      chk($sformatf("t6_nodone%0d", v), done, 0);
    end
    cyc();
    chk("t6_done", done, 4'b0001);
    req = '0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
